// File: rtl/stm_swapchain.sv
// stm_swapchain: two-segment STM read-pointer swap chain with triggered segment transitions.
// Optional GPIO trigger (2-flop synchronizer + edge detect) built when STM_GPIO_TRIGGER_EN is defined.
module stm_swapchain (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] SYS_TIME,
  input  logic        UPDATE_SETTINGS,
  input  logic        REQ_RD_SEGMENT,
  input  logic [7:0]  TRANSITION_MODE,
  input  logic [63:0] TRANSITION_VALUE,
  input  logic [31:0] REP,
  input  logic [3:0]  GPIO_IN,
  input  logic [12:0] IDX_0,
  input  logic [12:0] IDX_1,
  input  logic [12:0] CYCLE_0,
  input  logic [12:0] CYCLE_1,
  output logic        SEGMENT,
  output logic [12:0] IDX,
  output logic        STOP
);
  typedef enum logic [1:0] {IDLE, WAIT_START, RUN_INF, RUN_FIN} state_t;
  typedef enum logic [1:0] {M_SYNC, M_TIME, M_GPIO, M_IMM} mode_t;
  state_t state;
  mode_t mode, new_mode;
  logic req_seg;
  logic [63:0] tval;
  logic [31:0] rep, pass_cnt;
  logic [12:0] prev_0, prev_1, idx_act, idx_req, cyc_act;
  logic wrap_0, wrap_1, wrap_req, wrap_act, gpio_edge, trig;
`ifdef STM_GPIO_TRIGGER_EN
  localparam logic gpio_en = 1'b1;
  logic [3:0] sync_1, sync_2, sync_3;
  always_ff @(posedge CLK)
    {sync_3, sync_2, sync_1} <= RST ? '0 : {sync_2, sync_1, GPIO_IN};
  assign gpio_edge = sync_2[tval[1:0]] & ~sync_3[tval[1:0]];
`else
  localparam logic gpio_en = 1'b0;
  logic gpio_unused;
  assign gpio_unused = ^GPIO_IN;
  assign gpio_edge = 1'b0;
`endif
  always_comb new_mode = TRANSITION_MODE == 8'h00 ? M_SYNC :
                         TRANSITION_MODE == 8'h01 ? M_TIME :
                         (gpio_en && TRANSITION_MODE == 8'h02) ? M_GPIO : M_IMM;
  // CYCLE of 0 makes every cycle a wrap so single-index segments still count passes
  assign wrap_0   = CYCLE_0 == '0 || (prev_0 == CYCLE_0 && IDX_0 == '0);
  assign wrap_1   = CYCLE_1 == '0 || (prev_1 == CYCLE_1 && IDX_1 == '0);
  assign wrap_req = req_seg ? wrap_1 : wrap_0;
  assign wrap_act = SEGMENT ? wrap_1 : wrap_0;
  assign idx_act  = SEGMENT ? IDX_1 : IDX_0;
  assign idx_req  = req_seg ? IDX_1 : IDX_0;
  assign cyc_act  = SEGMENT ? CYCLE_1 : CYCLE_0;
  always_comb trig = state == WAIT_START &&
                     (mode == M_SYNC ? wrap_req :
                      mode == M_TIME ? SYS_TIME >= tval :
                      mode == M_GPIO ? gpio_edge : 1'b1);
  always_ff @(posedge CLK) begin
    prev_0 <= IDX_0;
    prev_1 <= IDX_1;
  end
  // a fresh capture takes precedence over a trigger of the request it replaces
  always_ff @(posedge CLK)
    if (RST) begin
      state    <= RUN_INF;
      SEGMENT  <= 1'b0;
      IDX      <= '0;
      STOP     <= 1'b0;
      pass_cnt <= '0;
      rep      <= '1;
      mode     <= M_IMM;
      req_seg  <= 1'b0;
      tval     <= '0;
    end else if (UPDATE_SETTINGS) begin
      rep <= REP;
      if (!STOP) IDX <= idx_act;
      if (REQ_RD_SEGMENT != SEGMENT) begin
        state   <= WAIT_START;
        req_seg <= REQ_RD_SEGMENT;
        mode    <= new_mode;
        tval    <= TRANSITION_VALUE;
      end else begin
        state    <= &REP ? RUN_INF : RUN_FIN;
        pass_cnt <= '0;
      end
    end else if (trig) begin
      SEGMENT  <= req_seg;
      IDX      <= idx_req;
      STOP     <= 1'b0;
      pass_cnt <= '0;
      state    <= &rep ? RUN_INF : RUN_FIN;
    end else if (!STOP) begin
      IDX <= idx_act;
      if (state == RUN_FIN && wrap_act) begin
        if (pass_cnt == rep) begin
          STOP <= 1'b1;
          IDX  <= cyc_act;
        end else pass_cnt <= pass_cnt + 32'd1;
      end
    end
endmodule

// File: tb/tb_stm_swapchain.sv
// tb_stm_swapchain: random + directed stimulus, per-cycle expectations from a pass-countdown reference model
module tb_stm_swapchain;
`ifdef STM_GPIO_TRIGGER_EN
  localparam bit GPIO_EN = 1'b1;
`else
  localparam bit GPIO_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, upd = 0, req_seg = 0;
  logic [63:0] sys_time = 0, tval = 0;
  logic [7:0] mode = 8'hFF;
  logic [31:0] rep = '1;
  logic [3:0] gpio = 0;
  logic [12:0] idx0 = 0, idx1 = 0, cyc0 = 15, cyc1 = 3;
  logic seg, stop;
  logic [12:0] idx;
  int checks = 0, failures = 0;
  logic [14:0] exp_q[$];
  bit m_seg, m_stop, m_pend, m_req;
  bit [12:0] m_idx;
  bit [7:0] m_mode;
  bit [63:0] m_tval;
  bit [31:0] m_rep;
  longint m_left;
  bit [12:0] prev[2];
  bit [3:0] gh[$] = '{4'd0, 4'd0, 4'd0};

  stm_swapchain dut (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .UPDATE_SETTINGS(upd),
    .REQ_RD_SEGMENT(req_seg), .TRANSITION_MODE(mode), .TRANSITION_VALUE(tval),
    .REP(rep), .GPIO_IN(gpio), .IDX_0(idx0), .IDX_1(idx1),
    .CYCLE_0(cyc0), .CYCLE_1(cyc1), .SEGMENT(seg), .IDX(idx), .STOP(stop)
  );

  always #5 clk = ~clk;

  // m_left counts the wraps still allowed before playback freezes; -1 means endless
  task automatic model();
    bit [12:0] cur[2], cy[2];
    bit w[2];
    bit t;
    int em;
    cur = '{idx0, idx1};
    cy = '{cyc0, cyc1};
    for (int n = 0; n < 2; n++) w[n] = cy[n] == 0 || (prev[n] == cy[n] && cur[n] == 0);
    em = m_mode == 8'h00 ? 0 : m_mode == 8'h01 ? 1 : (m_mode == 8'h02 && GPIO_EN) ? 2 : 3;
    t = m_pend && (em == 0 ? w[m_req] : em == 1 ? sys_time >= m_tval :
                   em == 2 ? (gh[1][m_tval[1:0]] && !gh[2][m_tval[1:0]]) : 1'b1);
    if (rst) begin
      m_seg = 0; m_idx = 0; m_stop = 0; m_pend = 0; m_req = 0;
      m_rep = '1; m_mode = 8'hFF; m_tval = 0; m_left = -1;
      gh = '{4'd0, 4'd0, 4'd0};
    end else begin
      gh.push_front(gpio);
      void'(gh.pop_back());
      if (upd) begin
        if (!m_stop) m_idx = cur[m_seg];
        m_rep = rep;
        if (req_seg != m_seg) begin
          m_pend = 1; m_req = req_seg; m_mode = mode; m_tval = tval;
        end else begin
          m_pend = 0;
          m_left = rep == 32'hFFFF_FFFF ? -1 : longint'(rep);
        end
      end else if (t) begin
        m_seg = m_req; m_idx = cur[m_req]; m_stop = 0; m_pend = 0;
        m_left = m_rep == 32'hFFFF_FFFF ? -1 : longint'(m_rep);
      end else if (!m_stop) begin
        if (!m_pend && m_left >= 0 && w[m_seg]) begin
          if (m_left == 0) begin m_stop = 1; m_idx = cy[m_seg]; end
          else begin m_left--; m_idx = cur[m_seg]; end
        end else m_idx = cur[m_seg];
      end
    end
    prev = cur;
    exp_q.push_back({m_seg, m_idx, m_stop});
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    upd = 0;
    idx0 = idx0 >= cyc0 ? 13'd0 : idx0 + 13'd1;
    idx1 = idx1 >= cyc1 ? 13'd0 : idx1 + 13'd1;
    sys_time = sys_time + 1;
  endtask

  task automatic request(input bit s, input logic [7:0] m, input logic [63:0] v, input logic [31:0] r);
    req_seg = s; mode = m; tval = v; rep = r; upd = 1;
    step();
  endtask

  always @(negedge clk)
    if (exp_q.size() != 0) begin
      logic [14:0] e;
      e = exp_q.pop_front();
      checks += 3;
      if (seg !== e[14]) begin
        failures++;
        $display("FAIL segment t=%0t got=%0d exp=%0d", $time, seg, e[14]);
      end
      if (idx !== e[13:1]) begin
        failures++;
        $display("FAIL idx t=%0t got=%0d exp=%0d", $time, idx, e[13:1]);
      end
      if (stop !== e[0]) begin
        failures++;
        $display("FAIL stop t=%0t got=%0d exp=%0d", $time, stop, e[0]);
      end
    end

  initial begin
    logic [7:0] modes[4] = '{8'h00, 8'h01, 8'h02, 8'hFF};
    int k;
    repeat (3) step();
    rst = 0;
    repeat (20) step();
    idx1 = 5;
    request(1, 8'h00, 0, '1);
    repeat (10) step();
    request(0, 8'hFF, 0, '1);
    repeat (3) step();
    request(1, 8'hFF, 0, 1);
    repeat (15) step();
    request(0, 8'hFF, 0, '1);
    repeat (4) step();
    sys_time = 990;
    request(1, 8'h01, 1000, '1);
    repeat (15) step();
    request(0, 8'hFF, 0, '1);
    repeat (2) step();
    request(1, 8'h02, 2, '1);
    gpio = 4'b0010;
    repeat (2) step();
    gpio = 0;
    repeat (5) step();
    gpio = 4'b0100;
    repeat (2) step();
    gpio = 0;
    repeat (5) step();
    request(0, 8'h01, sys_time + 10, '1);
    repeat (3) step();
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (20) step();
    cyc1 = 0;
    request(1, 8'hFF, 0, 0);
    repeat (5) step();
    cyc1 = 3;
    request(0, 8'hFF, 0, '1);
    request(1, 8'h01, 0, '1);
    request(1, 8'h00, 0, '1);
    repeat (8) step();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) begin
        cyc0 = 13'($urandom_range(0, 6));
        cyc1 = 13'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 7) == 0) gpio = 4'($urandom);
      rst = $urandom_range(0, 249) == 0;
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, 4);
        req_seg = 1'($urandom);
        mode = k == 4 ? 8'($urandom_range(3, 254)) : modes[k];
        tval = sys_time + 64'($urandom_range(0, 30));
        rep = $urandom_range(0, 4) == 0 ? '1 : 32'($urandom_range(0, 3));
        upd = 1;
      end
      step();
    end
    rst = 0;
    repeat (2) step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
